// File: rtl/nes_pad_reader.sv
// NES controller poller: once per frame request it strobes the latch, clocks out
// eight active-low button bits, and publishes a cleaned, active-high button word.
module nes_pad_reader #(
    parameter int unsigned HALF_PERIOD = 72,
    parameter bit          SOCD_CLEAN  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_rate,
    input  logic nes_data,
    output logic nes_latch,
    output logic nes_clk,
    output logic button_a,
    output logic button_b,
    output logic button_select,
    output logic button_start,
    output logic button_up,
    output logic button_down,
    output logic button_left,
    output logic button_right,
    output logic buttons_valid,
    output logic busy
);

    localparam logic [7:0] HalfLast = 8'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StSettle,
        StClkHi,
        StClkLo,
        StPublish
    } state_e;

    state_e     state_q;
    logic [7:0] cnt_q;
    logic [2:0] bit_q;
    logic [7:0] shift_q;
    logic [7:0] buttons_q;
    logic       latch_q;
    logic       nclk_q;
    logic       valid_q;
    logic       busy_q;
    logic       data_meta_q;
    logic       data_sync_q;
    logic [7:0] pressed;
    logic [7:0] cleaned;
    logic       phase_done;

    // Two-flop synchronizer; idles high so a floating line reads as "released".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            data_meta_q <= nes_data;
            data_sync_q <= data_meta_q;
        end
    end

    assign phase_done = (cnt_q == 8'd0);

    // Convert to active-high and drop opposing direction pairs.
    always_comb begin
        pressed = ~shift_q;
        cleaned = pressed;
        if (SOCD_CLEAN) begin
            if (pressed[4] && pressed[5]) cleaned[5:4] = 2'b00;
            if (pressed[6] && pressed[7]) cleaned[7:6] = 2'b00;
        end
    end

    // Poll sequencer; every phase is HALF_PERIOD long, the latch runs two phases
    // (bit_q counts them) so the 8-bit counter covers the full parameter range.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'hFF;
            buttons_q <= 8'h00;
            latch_q   <= 1'b0;
            nclk_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (frame_rate) begin
                        state_q <= StLatch;
                        latch_q <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= HalfLast;
                        bit_q   <= 3'd0;
                    end
                end
                StLatch: begin
                    if (phase_done) begin
                        cnt_q <= HalfLast;
                        if (bit_q == 3'd0) begin
                            bit_q <= 3'd1;
                        end else begin
                            bit_q   <= 3'd0;
                            latch_q <= 1'b0;
                            state_q <= StSettle;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StSettle: begin
                    if (phase_done) begin
                        shift_q[bit_q] <= data_sync_q;
                        bit_q          <= 3'd1;
                        nclk_q         <= 1'b1;
                        cnt_q          <= HalfLast;
                        state_q        <= StClkHi;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StClkHi: begin
                    if (phase_done) begin
                        nclk_q  <= 1'b0;
                        cnt_q   <= HalfLast;
                        state_q <= StClkLo;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StClkLo: begin
                    if (phase_done) begin
                        shift_q[bit_q] <= data_sync_q;
                        cnt_q          <= HalfLast;
                        if (bit_q == 3'd7) begin
                            busy_q  <= 1'b0;
                            state_q <= StPublish;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            nclk_q  <= 1'b1;
                            state_q <= StClkHi;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StPublish: begin
                    buttons_q <= cleaned;
                    valid_q   <= 1'b1;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign nes_latch     = latch_q;
    assign nes_clk       = nclk_q;
    assign buttons_valid = valid_q;
    assign busy          = busy_q;
    assign button_a      = buttons_q[0];
    assign button_b      = buttons_q[1];
    assign button_select = buttons_q[2];
    assign button_start  = buttons_q[3];
    assign button_up     = buttons_q[4];
    assign button_down   = buttons_q[5];
    assign button_left   = buttons_q[6];
    assign button_right  = buttons_q[7];

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: a behavioural shift-register controller, random and
// directed polls, a scoreboard on buttons_valid and a pin-timing monitor.
module tb_nes_pad_reader;

    localparam int unsigned HP      = 4;
    localparam int          PollLen = 17 * HP + 1;

    typedef struct {
        logic [7:0] w;
        longint     due;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    logic   frame_rate = 1'b0;
    logic   nes_data;
    longint cyc = 0;

    logic       d0_latch, d0_nclk, d0_valid, d0_busy;
    logic       d1_latch, d1_nclk, d1_valid, d1_busy;
    wire  [7:0] word0;
    wire  [7:0] word1;

    // Controller model: buttons held (active-high), 4021-style serial out.
    logic [7:0] pad_word = 8'h00;
    logic       disconnected = 1'b0;
    logic [3:0] pad_idx = 4'd0;

    int checks = 0;
    int errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    longint last_due;
    logic [7:0] shown0;
    int latch_rises = 0;
    int valid_seen = 0;
    int pulses = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge d0_nclk or posedge d0_latch) begin
        if (d0_latch) pad_idx <= 4'd0;
        else if (pad_idx < 4'd8) pad_idx <= pad_idx + 4'd1;
    end
    assign nes_data = disconnected | (pad_idx > 4'd7) | ~pad_word[pad_idx[2:0]];

    nes_pad_reader #(.HALF_PERIOD(HP), .SOCD_CLEAN(1'b1)) dut0 (
        .clk(clk), .reset(reset), .frame_rate(frame_rate), .nes_data(nes_data),
        .nes_latch(d0_latch), .nes_clk(d0_nclk),
        .button_a(word0[0]), .button_b(word0[1]), .button_select(word0[2]),
        .button_start(word0[3]), .button_up(word0[4]), .button_down(word0[5]),
        .button_left(word0[6]), .button_right(word0[7]),
        .buttons_valid(d0_valid), .busy(d0_busy)
    );

    nes_pad_reader #(.HALF_PERIOD(HP), .SOCD_CLEAN(1'b0)) dut1 (
        .clk(clk), .reset(reset), .frame_rate(frame_rate), .nes_data(nes_data),
        .nes_latch(d1_latch), .nes_clk(d1_nclk),
        .button_a(word1[0]), .button_b(word1[1]), .button_select(word1[2]),
        .button_start(word1[3]), .button_up(word1[4]), .button_down(word1[5]),
        .button_left(word1[6]), .button_right(word1[7]),
        .buttons_valid(d1_valid), .busy(d1_busy)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: held buttons as seen by the player, with optional SOCD rule.
    function automatic logic [7:0] model(input logic [7:0] held, input bit socd,
                                         input bit disc);
        logic [7:0] w;
        if (disc) return 8'h00;
        w = held;
        if (socd && w[4] && w[5]) begin w[4] = 1'b0; w[5] = 1'b0; end
        if (socd && w[6] && w[7]) begin w[6] = 1'b0; w[7] = 1'b0; end
        return w;
    endfunction

    // Called at posedge+1: request a poll and queue the expected words.
    task automatic poll_start(input logic [7:0] pad, input bit disc);
        exp_t e;
        pad_word     = pad;
        disconnected = disc;
        frame_rate   = 1'b1;
        @(posedge clk);
        #1 frame_rate = 1'b0;
        last_due = cyc + PollLen;
        e.due = last_due;
        e.w = model(pad, 1'b1, disc);
        q0.push_back(e);
        e.w = model(pad, 1'b0, disc);
        q1.push_back(e);
    endtask

    task automatic wait_done();
        if (last_due > cyc) repeat (int'(last_due - cyc)) @(posedge clk);
        #1;
        shown0 = model(pad_word, 1'b1, disconnected);
    endtask

    // Scoreboard: every buttons_valid pulse must match the oldest queued poll.
    always @(negedge clk) begin : scoreboard
        exp_t e;
        if (!reset) begin
            if (d0_valid) begin
                valid_seen++;
                if (q0.size() == 0) check("unexpected_valid0", 1, 0);
                else begin
                    e = q0.pop_front();
                    check("word_socd1", word0, e.w);
                    check("latency0", cyc, e.due);
                    check("clk_pulses", pulses, 7);
                end
            end
            if (d1_valid) begin
                if (q1.size() == 0) check("unexpected_valid1", 1, 0);
                else begin
                    e = q1.pop_front();
                    check("word_socd0", word1, e.w);
                    check("latency1", cyc, e.due);
                end
            end
        end
    end

    // Pin-timing monitor on the SOCD_CLEAN=1 instance.
    int latch_run = 0, hi_run = 0, lo_run = 0, busy_run = 0;
    logic prev_latch = 1'b0, prev_nclk = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            latch_run = 0; hi_run = 0; lo_run = 0; busy_run = 0;
            prev_latch = 1'b0; prev_nclk = 1'b0;
        end else begin
            if (d0_latch && d0_nclk) check("pins_exclusive", 1, 0);
            if (d0_latch && !prev_latch) begin
                latch_rises++;
                pulses = 0;
            end
            if (d0_latch) latch_run++;
            else if (latch_run != 0) begin
                check("latch_width", latch_run, 2 * HP);
                latch_run = 0;
            end
            if (d0_nclk && !prev_nclk) begin
                if (pulses != 0) check("clk_low_width", lo_run, HP);
                pulses++;
                lo_run = 0;
            end
            if (d0_nclk) hi_run++;
            else begin
                if (hi_run != 0) begin
                    check("clk_high_width", hi_run, HP);
                    hi_run = 0;
                end
                if (pulses != 0) lo_run++;
            end
            if (d0_busy) busy_run++;
            else if (busy_run != 0) begin
                check("busy_len", busy_run, 17 * HP);
                busy_run = 0;
            end
            prev_latch = d0_latch;
            prev_nclk  = d0_nclk;
        end
    end

    initial begin
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        int rises_before;
        logic [7:0] old_w, new_w, pad;
        shown0 = 8'h00;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_word0", word0, 0);
        check("rst_word1", word1, 0);
        check("rst_pins", {d0_latch, d0_nclk}, 0);
        check("rst_busy_valid", {d0_busy, d0_valid}, 0);
        reset = 1'b0;

        // Idle with no requests.
        repeat (100) @(posedge clk);
        #1;
        check("idle_latch_rises", latch_rises, 0);
        check("idle_valids", valid_seen, 0);
        check("idle_word", word0, 0);
        check("idle_busy", d0_busy, 0);

        // Up+A, then Left+Right+B (SOCD differs between instances).
        poll_start(8'b0001_0001, 1'b0);
        wait_done();
        poll_start(8'b1100_0010, 1'b0);
        wait_done();

        // Extra request mid-poll and another in the PUBLISH cycle are ignored.
        rises_before = latch_rises;
        poll_start(8'h28, 1'b0);
        repeat (20) @(posedge clk);
        #1 frame_rate = 1'b1;
        @(posedge clk);
        #1 frame_rate = 1'b0;
        repeat (int'(last_due - cyc - 1)) @(posedge clk);
        #1 frame_rate = 1'b1;
        @(posedge clk);
        #1 frame_rate = 1'b0;
        shown0 = model(pad_word, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("ignored_req_latches", latch_rises - rises_before, 1);
        check("ignored_req_busy", d0_busy, 0);

        // Pattern change after bit 3: outputs hold, then publish the mix.
        old_w = 8'($urandom);
        new_w = 8'($urandom);
        poll_start(old_w, 1'b0);
        repeat (40) @(posedge clk);
        #1 pad_word = new_w;
        repeat (10) @(posedge clk);
        #1 check("hold_mid_poll", word0, shown0);
        q0[q0.size() - 1].w = model({new_w[7:4], old_w[3:0]}, 1'b1, 1'b0);
        q1[q1.size() - 1].w = model({new_w[7:4], old_w[3:0]}, 1'b0, 1'b0);
        wait_done();

        // Disconnected controller.
        poll_start(8'hFF, 1'b1);
        wait_done();
        disconnected = 1'b0;

        // Reset during CLK_HI of bit 5 aborts the poll.
        poll_start(8'h5A, 1'b0);
        repeat (46) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_pins", {d0_latch, d0_nclk}, 0);
        check("abort_busy", d0_busy, 0);
        check("abort_word", word0, 0);
        q0.delete();
        q1.delete();
        shown0 = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        poll_start(8'h99, 1'b0);
        wait_done();

        // Random polls, some back-to-back, biased toward SOCD conflicts.
        for (int i = 0; i < 30; i++) begin
            pad = 8'($urandom);
            if ($urandom_range(0, 2) == 0) pad = pad | 8'hF0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            poll_start(pad, 1'b0);
            wait_done();
        end

        repeat (10) @(posedge clk);
        #1;
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nes_pad_reader.md
Name: nes_pad_reader

Overview:
- Polls a NES-style serial game controller once per frame.
- Generates the controller latch and clock, shifts in 8 active-low button bits, and publishes a cleaned, registered, active-high button word.
- Sits between the off-board controller pins and movement_FSM; its button_up/down/left/right outputs feed the FSM inputs directly.
- One instance per player.

Parameters:
- HALF_PERIOD, 72, system clock cycles per controller half-period (6 us at 12 MHz); legal range 4..255.
- SOCD_CLEAN, 1, when 1, opposing directions pressed together are both forced to 0.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- frame_rate  input  1  one-cycle poll request, the same frame tick movement_FSM uses.
- nes_data  input  1  serial data from the controller, active-low, asynchronous to clk.
- nes_latch  output  1  latch strobe to the controller.
- nes_clk  output  1  shift clock to the controller.
- button_a, button_b, button_select, button_start  output  1 each  active-high, registered.
- button_up, button_down, button_left, button_right  output  1 each  active-high, registered.
- buttons_valid  output  1  one-cycle pulse when the button outputs update.
- busy  output  1  high while a poll is in progress.

Behaviour:
- Reset is asynchronous and active-high. While asserted: state IDLE, nes_latch=0, nes_clk=0, all buttons=0, buttons_valid=0, busy=0, counters=0, shift register=8'hFF.
- The nes_data 2-flop synchronizer resets to 1 (released/idle level).
- Reset mid-poll aborts the poll. Pins drop low immediately, the previous button word is discarded, and the reader restarts cleanly in IDLE.
- Sampling uses the synchronized nes_data only.
- One down-counter, 8 bits wide, times every phase. A bit index counter runs 0..7.
- FSM states:
  - IDLE: busy=0. A frame_rate pulse enters LATCH on the next edge.
  - LATCH: nes_latch=1 for 2*HALF_PERIOD cycles, then go to SETTLE.
  - SETTLE: both pins low for HALF_PERIOD cycles. On the last cycle, sample bit 0 (A).
  - CLK_HI: nes_clk=1 for HALF_PERIOD cycles, then go to CLK_LO.
  - CLK_LO: nes_clk=0 for HALF_PERIOD cycles. On the last cycle, sample bit index i. After i=7, go to PUBLISH; otherwise go to CLK_HI.
  - PUBLISH: one cycle. Invert the shift register, apply SOCD cleaning, register the outputs, pulse buttons_valid=1, return to IDLE.
- Bit order: 0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right. Seven clock pulses are needed for bits 1..7.
- Poll length from the frame_rate edge to the buttons_valid pulse is 17*HALF_PERIOD+1 cycles. busy is high for exactly that span, excluding the PUBLISH cycle.
- Outputs change only in PUBLISH, so the button word is never torn mid-poll. Between polls the outputs hold their last value.
- frame_rate while busy is ignored; there is no queueing. frame_rate in the PUBLISH cycle is also ignored.
- frame_rate in IDLE on the cycle right after PUBLISH starts a new poll.
- SOCD cleaning (SOCD_CLEAN=1):
  - up and down both pressed: both outputs are 0.
  - left and right both pressed: both outputs are 0.
  - A, B, Select and Start are never altered.
- Disconnected controller: nes_data floats or is pulled high, reads as all 1s, and publishes all buttons=0. No error flag is raised.
- nes_latch and nes_clk are registered outputs with no glitches. They are never high at the same time.

Test Plan (HALF_PERIOD=4, poll = 69 cycles):
- Reset released, no frame_rate for 100 cycles -> pins stay 0, all buttons=0, busy=0, buttons_valid never pulses.
- frame_rate pulse, controller model drives the pattern for Up+A held (raw bits 0,4 low) -> nes_latch high exactly 8 cycles; exactly 7 nes_clk pulses, each 4 high/4 low; buttons_valid 69 cycles after the request; button_a=1, button_up=1, all others 0.
- Left+Right+B held, SOCD_CLEAN=1 -> button_b=1, button_left=0, button_right=0. Same stimulus with SOCD_CLEAN=0 -> all three =1.
- Second frame_rate pulse 20 cycles into a poll -> ignored. Only one buttons_valid pulse, and no new latch until the next request after PUBLISH.
- Controller pattern changed mid-poll after bit 3 is sampled -> outputs stay at the previous word until PUBLISH, then show the mixed sample in a single update.
- reset asserted during CLK_HI of bit 5 -> nes_clk and nes_latch drop to 0 asynchronously, buttons go to 0, busy=0. After release, a new frame_rate produces a full 69-cycle poll with correct data.
